// File: rtl/layer_mvm_stream.sv
// Fully-connected layer engine: y = W*x + b over a valid/ready stream.
// Coefficients live in a writable RAM (W row-major, then biases); P MAC lanes
// each produce one output row per pass, followed by optional saturation/ReLU.
module layer_mvm_stream #(
    parameter int M    = 4,
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int P    = 2,
    parameter int SAT  = 1,
    parameter int RELU = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [T-1:0]      data_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [T-1:0]      data_out,
    input  logic                     w_en,
    input  logic [$clog2(M*N+M)-1:0] w_addr,
    input  logic signed [T-1:0]      w_data
);
    localparam int DEPTH  = M * N + M;
    localparam int CA     = $clog2(DEPTH);
    localparam int PASSES = M / P;
    localparam int MW     = 2 * T;
    localparam int AW     = 2 * T + $clog2(N) + 1;
    localparam int XW     = (N > 1) ? $clog2(N) : 1;
    localparam int YW     = (M > 1) ? $clog2(M) : 1;
    localparam int QW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int CW     = $clog2(N + 2);

    localparam logic signed [AW-1:0] SMAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};
    localparam logic signed [T-1:0]  TMAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0]  TMIN = {1'b1, {(T-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

    state_t              state, state_nxt;
    logic [XW-1:0]       in_cnt;
    logic [CW-1:0]       mac_cnt;
    logic [QW-1:0]       pass_cnt;
    logic [YW-1:0]       out_cnt;
    logic                vld_p0, vld_p1;
    logic                in_last, mac_last, pass_last, out_last, beat_in, beat_out;

    logic signed [T-1:0]  coef  [DEPTH];
    logic signed [T-1:0]  x_mem [N];
    logic signed [T-1:0]  y_mem [M];
    logic signed [T-1:0]  w_p0  [P];
    logic signed [T-1:0]  x_p0;
    logic signed [MW-1:0] prod_p1 [P];
    logic signed [AW-1:0] acc_p2  [P];
    logic signed [T-1:0]  res     [P];
    logic [CA-1:0]        w_rd_addr [P];
    logic [CA-1:0]        b_rd_addr [P];
    logic [YW-1:0]        row_idx   [P];

    // Saturate (or wrap) the accumulator to T bits, then optionally clamp negatives.
    function automatic logic signed [T-1:0] post(input logic signed [AW-1:0] a);
        logic signed [T-1:0] r;
        r = a[T-1:0];
        if (SAT == 1) begin
            if (a > SMAX)      r = TMAX;
            else if (a < SMIN) r = TMIN;
        end
        if (RELU == 1 && r[T-1]) r = '0;
        return r;
    endfunction

    assign in_last   = (in_cnt == XW'(N - 1));
    assign mac_last  = (mac_cnt == CW'(N + 1));
    assign pass_last = (pass_cnt == QW'(PASSES - 1));
    assign out_last  = (out_cnt == YW'(M - 1));
    assign beat_in   = s_valid && s_ready;
    assign beat_out  = m_valid && m_ready;

    // Next state and input handshake; s_ready held low while reset is asserted.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            LOAD: begin
                s_ready = reset;
                if (s_valid && reset && in_last) state_nxt = MAC;
            end
            MAC:  if (mac_last && pass_last) state_nxt = OUT;
            OUT:  if (beat_out && out_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nxt;
    end

    // Counters, pipeline valids and the registered output beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt   <= '0;
            mac_cnt  <= '0;
            pass_cnt <= '0;
            out_cnt  <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            m_valid  <= 1'b0;
            data_out <= '0;
        end else begin
            vld_p0 <= (state == MAC) && (mac_cnt < CW'(N));
            vld_p1 <= vld_p0;
            case (state)
                LOAD: if (beat_in) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
                MAC: begin
                    if (mac_last) begin
                        mac_cnt <= '0;
                        if (pass_last) begin
                            pass_cnt <= '0;
                            out_cnt  <= '0;
                            m_valid  <= 1'b1;
                            // With a single pass, row 0 is being written this very edge.
                            data_out <= (PASSES == 1) ? res[0] : y_mem[0];
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end else begin
                        mac_cnt <= mac_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (beat_out) begin
                        if (out_last) begin
                            out_cnt <= '0;
                            m_valid <= 1'b0;
                        end else begin
                            out_cnt  <= out_cnt + 1'b1;
                            data_out <= y_mem[out_cnt + 1'b1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-lane RAM addresses and post-processed result of the final accumulate.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            row_idx[p]   = YW'(int'(pass_cnt) * P + p);
            w_rd_addr[p] = CA'((int'(pass_cnt) * P + p) * N + int'(mac_cnt));
            b_rd_addr[p] = CA'(M * N + int'(pass_cnt) * P + p);
            res[p]       = post(acc_p2[p] + AW'(prod_p1[p]));
        end
    end

    // Storage and MAC datapath (not reset: contents are meaningless until written).
    always_ff @(posedge clk) begin
        if (w_en && state != MAC && 32'(w_addr) < 32'(DEPTH)) coef[w_addr] <= w_data;
        if (state == LOAD && beat_in) x_mem[in_cnt] <= data_in;
        // p0: coefficient and input reads for column mac_cnt
        if (state == MAC && mac_cnt < CW'(N)) begin
            x_p0 <= x_mem[XW'(mac_cnt)];
            for (int p = 0; p < P; p++) w_p0[p] <= coef[w_rd_addr[p]];
        end
        // p1: registered products
        for (int p = 0; p < P; p++) prod_p1[p] <= MW'(w_p0[p]) * MW'(x_p0);
        // p2: bias-seeded accumulation; final sum lands in y on the last pass cycle
        for (int p = 0; p < P; p++) begin
            if (state == MAC && mac_cnt == '0) acc_p2[p] <= AW'(coef[b_rd_addr[p]]);
            else if (vld_p1)                   acc_p2[p] <= acc_p2[p] + AW'(prod_p1[p]);
            if (vld_p1 && mac_last) y_mem[row_idx[p]] <= res[p];
        end
    end
endmodule
